// File: rtl/ray_dir_reciprocal_pkg.sv
// ray_dir_reciprocal_pkg: shared types, Q-format widths and reciprocal constants
// Provides vec3 (Q10.18 components) and vec3_18_18 (Q18.18 components), both
// packed [2:0] with index 0 = x, plus recip_form() for saturation, sign and zero handling.
package ray_dir_reciprocal_pkg;
  localparam int DIR_W = 28;
  localparam int INV_W = 36;
  localparam int DIV_ITERS = 37;
  localparam int Q_FRAC = 18;
  localparam logic [DIV_ITERS-1:0] RECIP_DIVIDEND = 37'h10_0000_0000;
  localparam logic [DIV_ITERS-1:0] RECIP_MAX_36 = 37'h07_FFFF_FFFF;
  typedef logic [2:0][DIR_W-1:0] vec3;
  typedef logic [2:0][INV_W-1:0] vec3_18_18;
  function automatic logic [INV_W-1:0] recip_form(input logic [DIV_ITERS-1:0] q, input logic neg,
                                                  input logic zero);
    logic [INV_W-1:0] m;
    m = (q > RECIP_MAX_36) ? RECIP_MAX_36[INV_W-1:0] : q[INV_W-1:0];
    return zero ? '0 : neg ? -m : m;
  endfunction
endpackage

// File: rtl/ray_dir_reciprocal_div_core.sv
// recip_div_core: restoring unsigned divider of 2^36 by a DIR_W-bit divisor
// Ports: clk, rst; i_start (load dividend and do the first step), i_en (do one more step),
// i_divisor (held stable by the caller for the whole division); o_quotient (37 bits),
// o_done (all DIV_ITERS quotient bits produced).
module recip_div_core
  import ray_dir_reciprocal_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_en,
  input  logic [DIR_W-1:0]     i_divisor,
  output logic [DIV_ITERS-1:0] o_quotient,
  output logic                 o_done
);
  logic [DIR_W-1:0] r_rem, w_rem_in, w_sub;
  logic [DIV_ITERS-1:0] r_quo, w_quo_in;
  logic [5:0] r_cnt;
  logic [DIR_W:0] w_sh;
  logic w_ge;
  // The quotient register starts holding the dividend; its MSB shifts into the
  // remainder while quotient bits shift in at the bottom.
  assign w_rem_in = i_start ? '0 : r_rem;
  assign w_quo_in = i_start ? RECIP_DIVIDEND : r_quo;
  assign w_sh = {w_rem_in, w_quo_in[DIV_ITERS-1]};
  assign w_ge = w_sh >= {1'b0, i_divisor};
  // The remainder stays below the divisor, so the difference fits in DIR_W bits.
  assign w_sub = w_sh[DIR_W-1:0] - i_divisor;
  assign o_quotient = r_quo;
  assign o_done = r_cnt == 6'(DIV_ITERS);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
    end else if (i_start | i_en) begin
      r_rem <= w_ge ? w_sub : w_sh[DIR_W-1:0];
      r_quo <= {w_quo_in[DIV_ITERS-2:0], w_ge};
      r_cnt <= i_start ? 6'd1 : r_cnt + 6'd1;
    end
  end
endmodule

// File: rtl/ray_dir_reciprocal.sv
// ray_dir_reciprocal: per-axis Q18.18 reciprocal of a Q10.18 ray direction
// Ports: clk, rst (sync, active-high); in_valid/in_ready accept ray_dir and ray_orig_in;
// out_valid/out_ready present ray_orig_out, inv_ray_dir and div_by_zero (bit0 = x).
// Macro RECIP_SINGLE_DIV_EN: one time-shared divider (x, y, z), latency 112 instead of 38.
module ray_dir_reciprocal
  import ray_dir_reciprocal_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  vec3        ray_orig_in,
  input  vec3        ray_dir,
  output logic       out_valid,
  input  logic       out_ready,
  output vec3        ray_orig_out,
  output vec3_18_18  inv_ray_dir,
  output logic [2:0] div_by_zero
);
  localparam logic [1:0] S_IDLE = 2'd0, S_DIVIDE = 2'd1, S_DONE = 2'd2;
  logic [1:0] r_state;
  logic r_go;
  logic [2:0] r_neg, r_zero;
  logic [2:0][DIR_W-1:0] r_mag;
  logic w_acc, w_busy, w_start, w_en, w_fin;
  vec3_18_18 w_res;
  assign in_ready = r_state == S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign w_acc = in_valid & in_ready;
  // r_go marks the first DIVIDE cycle, where the divider is started from the captured magnitudes.
  assign w_busy = (r_state == S_DIVIDE) & ~r_go;
`ifdef RECIP_SINGLE_DIV_EN
  logic [1:0] r_axis, w_sel;
  logic [DIR_W-1:0] w_div;
  logic [DIV_ITERS-1:0] w_q;
  logic w_done;
  logic [INV_W-1:0] r_part0, r_part1, w_form;
  // Finishing one axis and starting the next share a cycle, keeping 37 cycles per axis.
  assign w_sel = (w_busy & w_done) ? r_axis + 2'd1 : r_axis;
  assign w_div = w_sel == 2'd0 ? r_mag[0] : w_sel == 2'd1 ? r_mag[1] : r_mag[2];
  assign w_start = r_go | (w_busy & w_done & (r_axis != 2'd2));
  assign w_en = w_busy & ~w_done;
  assign w_fin = w_busy & w_done & (r_axis == 2'd2);
  assign w_form = recip_form(w_q, r_neg[r_axis], r_zero[r_axis]);
  assign w_res = {w_form, r_part1, r_part0};
  recip_div_core u_div (
    .clk(clk), .rst(rst), .i_start(w_start), .i_en(w_en), .i_divisor(w_div),
    .o_quotient(w_q), .o_done(w_done)
  );
  always_ff @(posedge clk) begin
    if (rst | w_acc) begin
      r_axis <= '0;
      r_part0 <= '0;
      r_part1 <= '0;
    end else if (w_busy & w_done & (r_axis != 2'd2)) begin
      r_axis <= r_axis + 2'd1;
      if (r_axis[0]) r_part1 <= w_form;
      else r_part0 <= w_form;
    end
  end
`else
  logic [2:0] w_dn;
  logic [2:0][DIV_ITERS-1:0] w_q;
  assign w_start = r_go;
  assign w_en = w_busy & ~(&w_dn);
  assign w_fin = w_busy & (&w_dn);
  for (genvar a = 0; a < 3; a++) begin : g_div
    recip_div_core u_div (
      .clk(clk), .rst(rst), .i_start(w_start), .i_en(w_en), .i_divisor(r_mag[a]),
      .o_quotient(w_q[a]), .o_done(w_dn[a])
    );
    assign w_res[a] = recip_form(w_q[a], r_neg[a], r_zero[a]);
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_go <= 1'b0;
      r_neg <= '0;
      r_zero <= '0;
      r_mag <= '0;
      ray_orig_out <= '0;
      inv_ray_dir <= '0;
      div_by_zero <= '0;
    end else begin
      r_go <= w_acc;
      if (w_acc) begin
        r_state <= S_DIVIDE;
        ray_orig_out <= ray_orig_in;
        for (int i = 0; i < 3; i++) begin
          r_neg[i] <= ray_dir[i][DIR_W-1];
          r_zero[i] <= ray_dir[i] == '0;
          r_mag[i] <= ray_dir[i][DIR_W-1] ? -ray_dir[i] : ray_dir[i];
        end
      end
      if (w_fin) begin
        r_state <= S_DONE;
        inv_ray_dir <= w_res;
        div_by_zero <= r_zero;
      end
      if (out_valid & out_ready) r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_ray_dir_reciprocal.sv
// tb_ray_dir_reciprocal: directed self-checking bench for ray_dir_reciprocal
module tb_ray_dir_reciprocal;
  import ray_dir_reciprocal_pkg::*;
`ifdef RECIP_SINGLE_DIV_EN
  localparam int LAT = 112;
`else
  localparam int LAT = 38;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [2:0] div_by_zero;
  vec3 ray_orig_in = '0, ray_dir = '0, ray_orig_out;
  vec3_18_18 inv_ray_dir, held;
  int n_vec = 0, n_bad = 0, lat;
  always #5 clk = ~clk;
  ray_dir_reciprocal dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ray_orig_in(ray_orig_in), .ray_dir(ray_dir), .out_valid(out_valid),
    .out_ready(out_ready), .ray_orig_out(ray_orig_out), .inv_ray_dir(inv_ray_dir),
    .div_by_zero(div_by_zero)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [27:0] x, input logic [27:0] y, input logic [27:0] z,
                       input logic [27:0] o);
    ray_dir[0] = x;
    ray_dir[1] = y;
    ray_dir[2] = z;
    ray_orig_in[0] = o;
    ray_orig_in[1] = o + 28'd1;
    ray_orig_in[2] = o + 28'd2;
    in_valid = 1'b1;
  endtask
  task automatic wait_result(output int n);
    n = 0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    while (!out_valid && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", 64'(n), 64'(LAT));
  endtask
  task automatic send(input logic [27:0] x, input logic [27:0] y, input logic [27:0] z,
                      input logic [27:0] o);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    drive(x, y, z, o);
    wait_result(lat);
  endtask
  task automatic expect_out(input string tag, input logic [35:0] e0, input logic [35:0] e1,
                            input logic [35:0] e2, input logic [2:0] dz, input logic [27:0] o);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_inv_x"}, 64'(inv_ray_dir[0]), 64'(e0));
    chk({tag, "_inv_y"}, 64'(inv_ray_dir[1]), 64'(e1));
    chk({tag, "_inv_z"}, 64'(inv_ray_dir[2]), 64'(e2));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(dz));
    chk({tag, "_orig_x"}, 64'(ray_orig_out[0]), 64'(o));
    chk({tag, "_orig_z"}, 64'(ray_orig_out[2]), 64'(o + 28'd2));
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("handoff_valid", 64'(out_valid), 64'd0);
    chk("handoff_ready", 64'(in_ready), 64'd1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_inv", 64'(|inv_ray_dir), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_orig", 64'(|ray_orig_out), 64'd0);
    send(28'd262144, -28'd524288, 28'd786432, 28'd100);
    expect_out("v1", 36'd262144, -36'd131072, 36'd87381, 3'b000, 28'd100);
    release_out();
    send(28'd0, 28'd131072, 28'h8000000, 28'd200);
    expect_out("v2", 36'd0, 36'd524288, -36'd512, 3'b001, 28'd200);
    release_out();
    send(28'd1, -28'd2, 28'd3, 28'd300);
    expect_out("v3", 36'd34359738367, -36'd34359738367, 36'd22906492245, 3'b000, 28'd300);
    release_out();
    send(28'd262144, -28'd524288, 28'd786432, 28'd400);
    held = inv_ray_dir;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_ready", 64'(in_ready), 64'd0);
      chk("stall_hold", 64'(inv_ray_dir === held), 64'd1);
    end
    expect_out("v4", 36'd262144, -36'd131072, 36'd87381, 3'b000, 28'd400);
    out_ready = 1'b1;
    drive(28'd0, 28'd131072, 28'h8000000, 28'd500);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_not_taken", 64'(in_ready), 64'd1);
    chk("b2b_valid_low", 64'(out_valid), 64'd0);
    wait_result(lat);
    expect_out("v5", 36'd0, 36'd524288, -36'd512, 3'b001, 28'd500);
    release_out();
    @(negedge clk);
    drive(28'd1, -28'd2, 28'd3, 28'd600);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_inv", 64'(|inv_ray_dir), 64'd0);
    chk("midrst_dbz", 64'(div_by_zero), 64'd0);
    chk("midrst_orig", 64'(|ray_orig_out), 64'd0);
    send(28'd262144, -28'd524288, 28'd786432, 28'd700);
    expect_out("v6", 36'd262144, -36'd131072, 36'd87381, 3'b000, 28'd700);
    release_out();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
